// File: rtl/mult_pipe_hs_if.sv
// Handshake bundle for mult_pipe_hs: operand input channel, product output
// channel and the in-flight occupancy count.
// master: the side that drives operands and consumes products.
// slave : the multiplier pipeline itself.
interface mult_pipe_hs_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N-1:0]             mult1;
    logic [M-1:0]             mult2;
    logic                     sgn;
    logic                     out_valid;
    logic                     out_ready;
    logic [N+M-1:0]           res;
    logic [$clog2(M+1)-1:0]   inflight;

    modport master (
        output in_valid, mult1, mult2, sgn, out_ready,
        input  in_ready, out_valid, res, inflight
    );

    modport slave (
        input  in_valid, mult1, mult2, sgn, out_ready,
        output in_ready, out_valid, res, inflight
    );
endinterface

// File: rtl/mult_pipe_hs.sv
// mult_pipe_hs: M-stage shift-add multiplier with valid/ready handshake.
// Stage i adds (mult1 << i) when bit i of mult2 is set; the last stage is the
// output register, so a product appears M cycles after its acceptance edge.
// A stalled output (out_valid && !out_ready) freezes the whole pipeline.
// Optional macro MULT_SIGNED_EN: honour sgn as a two's-complement pair by
// sign-extending mult1 and subtracting the bit M-1 partial product.
module mult_pipe_hs #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    mult_pipe_hs_if.slave    hs
);
    localparam int W  = N + M;
    localparam int CW = $clog2(M + 1);

    logic         valid_q  [M];
    logic [W-1:0] sum_q    [M];
    logic [W-1:0] mcand_q  [M];
    logic [M-1:0] mplier_q [M];
    logic         sgn_q    [M];

    logic         valid_d  [M];
    logic [W-1:0] sum_d    [M];
    logic [W-1:0] mcand_d  [M];
    logic [M-1:0] mplier_d [M];
    logic         sgn_d    [M];

    logic [CW-1:0] inflight_q, inflight_d;

    logic         stall;
    logic         accept;
    logic         drain;
    logic [W-1:0] ext;
    logic [W-1:0] pp;

    // Handshake decode: only an unaccepted output can hold the pipe.
    always_comb begin
        stall  = valid_q[M-1] && !hs.out_ready;
        accept = hs.in_valid && !stall;
        drain  = valid_q[M-1] && hs.out_ready;
    end

    assign hs.in_ready  = !stall;
    assign hs.out_valid = valid_q[M-1];
    assign hs.res       = sum_q[M-1];
    assign hs.inflight  = inflight_q;

    // Next-state for every stage; data only moves with a valid item, so
    // bubbles leave old data in place and res keeps its last product.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            valid_d[i]  = valid_q[i];
            sum_d[i]    = sum_q[i];
            mcand_d[i]  = mcand_q[i];
            mplier_d[i] = mplier_q[i];
            sgn_d[i]    = sgn_q[i];
        end
        pp = '0;
`ifdef MULT_SIGNED_EN
        ext = {{M{hs.sgn & hs.mult1[N-1]}}, hs.mult1};
`else
        ext = {{M{1'b0}}, hs.mult1};
`endif
        if (!stall) begin
            valid_d[0] = hs.in_valid;
            if (hs.in_valid) begin
                sum_d[0]    = hs.mult2[0] ? ext : '0;
                mcand_d[0]  = ext << 1;
                mplier_d[0] = hs.mult2 >> 1;
                sgn_d[0]    = hs.sgn;
            end
            for (int i = 1; i < M; i++) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    pp          = mplier_q[i-1][0] ? mcand_q[i-1] : '0;
                    sum_d[i]    = sum_q[i-1] + pp;
`ifdef MULT_SIGNED_EN
                    if (i == M - 1 && sgn_q[i-1]) begin
                        sum_d[i] = sum_q[i-1] - pp;
                    end
`endif
                    mcand_d[i]  = mcand_q[i-1] << 1;
                    mplier_d[i] = mplier_q[i-1] >> 1;
                    sgn_d[i]    = sgn_q[i-1];
                end
            end
        end
    end

    // Occupancy: accept and drain on the same edge cancel out.
    always_comb begin
        inflight_d = inflight_q;
        case ({accept, drain})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Stage registers with synchronous reset discarding everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                valid_q[i]  <= 1'b0;
                sum_q[i]    <= '0;
                mcand_q[i]  <= '0;
                mplier_q[i] <= '0;
                sgn_q[i]    <= 1'b0;
            end
            inflight_q <= '0;
        end else begin
            for (int i = 0; i < M; i++) begin
                valid_q[i]  <= valid_d[i];
                sum_q[i]    <= sum_d[i];
                mcand_q[i]  <= mcand_d[i];
                mplier_q[i] <= mplier_d[i];
                sgn_q[i]    <= sgn_d[i];
            end
            inflight_q <= inflight_d;
        end
    end

    // The output stage has no successor for its multiplicand, multiplier
    // remainder or sign, which are carried only to keep stages uniform.
    logic unused_tail;
    assign unused_tail = ^{mcand_q[M-1], mplier_q[M-1], sgn_q[M-1]};
endmodule

// File: doc/mult_pipe_hs.md
MULT_PIPE_HS -- requirements
Module: mult_pipe_hs

Interface
REQ-001 Parameter N, default 8: mult1 operand width in bits, N >= 2.
REQ-002 Parameter M, default 4: mult2 operand width in bits and pipeline depth in stages, M >= 2.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port in_valid, input, 1: mult1, mult2 and sgn carry a valid operand pair.
REQ-006 Port in_ready, output, 1: block accepts an operand pair this cycle.
REQ-007 Port mult1, input, N: multiplicand.
REQ-008 Port mult2, input, M: multiplier.
REQ-009 Port sgn, input, 1: operand pair is two's complement (honoured only per REQ-027).
REQ-010 Port out_valid, output, 1: res holds a valid product.
REQ-011 Port out_ready, input, 1: downstream accepts res this cycle.
REQ-012 Port res, output, N+M: product.
REQ-013 Port inflight, output, clog2(M+1): number of operand pairs currently held in stages 0..M-1.

Function
REQ-014 A pair SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-015 The block SHALL be an M-stage shift-add pipeline; stage i adds (mult1 << i) to its partial sum when bit i of mult2 is 1.
REQ-016 Each stage SHALL carry its own valid bit, partial sum (N+M bits), the shifted multiplicand, the remaining multiplier bits and sgn.
REQ-017 Stall condition: out_valid && !out_ready; while stalled, all stages, out_valid and res SHALL hold their values.
REQ-018 in_ready SHALL equal !(out_valid && !out_ready), combinationally.
REQ-019 With no stall, res and out_valid SHALL be asserted exactly M cycles after the acceptance edge.
REQ-020 Throughput SHALL be one pair per cycle; bubbles (in_valid=0) SHALL propagate as invalid stages, and no stage SHALL ever be duplicated or dropped.
REQ-021 An item SHALL leave the output on a rising edge where out_valid && out_ready; the edge that completes a stall SHALL shift the whole pipeline by one stage.
REQ-022 If in_valid and in_ready are high on the same edge that the last stage drains, the new pair SHALL be accepted with no lost cycle.
REQ-023 res SHALL be the exact N+M-bit product with no overflow or truncation; unsigned when sgn=0.
REQ-024 res SHALL hold its last valid value while out_valid=0.
REQ-025 inflight SHALL increment on accept, decrement on output handshake, and stay unchanged when both occur on the same edge; it SHALL never exceed M.

Reset
REQ-026 While rst=1 at a rising edge: all stage valid bits, out_valid, res and inflight SHALL be cleared to 0, and in_ready SHALL be 1 from the next cycle; items in flight SHALL be discarded without producing output.

Configuration
REQ-027 Macro MULT_SIGNED_EN: when it is defined and sgn=1, mult1 SHALL be sign-extended to N+M bits and the final stage SHALL subtract the partial product for bit M-1 of mult2, so that res is the two's-complement product; without the macro, sgn SHALL be ignored and every product is unsigned.

Verification (N=8, M=4)
REQ-028 Accept 25x5 at cycle t with out_ready=1 -> out_valid=1 and res=125 at t+4.
REQ-029 Back-to-back pairs 255x15, 16x10, 10x4 on consecutive cycles -> res=3825, 160, 40 on consecutive cycles starting at acceptance+4.
REQ-030 Fill the pipeline and hold out_ready=0 for 5 cycles -> in_ready=0, res and inflight=4 stable during the stall; with out_ready=1, all four results appear in order with no loss.
REQ-031 Assert rst with 3 items in flight -> out_valid=0, inflight=0 and res=0 after the edge; no stale result appears afterwards.
REQ-032 With MULT_SIGNED_EN defined, sgn=1, mult1=8'hFD (-3), mult2=4'h8 (-8) -> res=12'h018 (24); with the macro undefined -> res=253x8=12'h7E8.
REQ-033 Random sweep of 10000 pairs with random in_valid and out_ready -> every res matches a reference model queue; inflight <= 4 at all times.
